// File: rtl/multicycle_ctrl_hs.sv
// rtl/multicycle_ctrl_hs.sv - multi-cycle MIPS control FSM with memory handshake, stall timeout and retire counter
// Optional macro CTRL_EXT_EN adds the ADDI_EXE, ADDI_WB and BNE states.
module multicycle_ctrl_hs #(
   parameter int STALL_MAX = 16,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       inst,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             BranchNE,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUop,
   output logic [1:0]       PCSource,
   output logic             err,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,
      WB_LW    = 4'd5,
      MEM_WR   = 4'd6,
      R_EXE    = 4'd7,
      R_WB     = 4'd8,
      BEQ      = 4'd9,
      JUMP     = 4'd10,
`ifdef CTRL_EXT_EN
      ADDI_EXE = 4'd11,
      ADDI_WB  = 4'd12,
      BNE      = 4'd13,
`endif
      ERR      = 4'd15
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_EXT_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam int WW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(STALL_MAX - 1);

   state_t        state, next_state;
   logic [WW-1:0] wait_cnt;
   logic          mem_wait, timeout, retire;

   assign mem_wait = (state == FETCH || state == MEM_RD || state == MEM_WR) && !mem_ready;
   // STALL_MAX of 0 disables the trap; the counter then just wraps unobserved.
   assign timeout  = (STALL_MAX != 0) && !mem_ready && (wait_cnt == WAIT_LAST);
   assign state_o  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         retired  <= '0;
      end else begin
         state <= next_state;
         if (mem_wait && next_state == state)
            wait_cnt <= wait_cnt + WW'(1);
         else
            wait_cnt <= '0;
         if (retire)
            retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      next_state  = state;
      retire      = 1'b0;
      mem_req     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNE    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUop       = 2'b00;
      PCSource    = 2'b00;
      err         = 1'b0;
      case (state)
         IDLE: next_state = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            // IR and PC load only on the completing cycle so a stall never double-steps the PC
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready)    next_state = DECODE;
            else if (timeout) next_state = ERR;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            case (inst)
               OP_LW, OP_SW: next_state = MEM_ADDR;
               OP_RTYPE:     next_state = R_EXE;
               OP_BEQ:       next_state = BEQ;
               OP_J:         next_state = JUMP;
`ifdef CTRL_EXT_EN
               OP_ADDI:      next_state = ADDI_EXE;
               OP_BNE:       next_state = BNE;
`endif
               default:      next_state = ERR;
            endcase
         end
         MEM_ADDR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            next_state = (inst == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready)    next_state = WB_LW;
            else if (timeout) next_state = ERR;
         end
         WB_LW: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            next_state = FETCH;
            retire     = 1'b1;
         end
         MEM_WR: begin
            mem_req  = 1'b1;
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               next_state = FETCH;
               retire     = 1'b1;
            end else if (timeout) begin
               next_state = ERR;
            end
         end
         R_EXE: begin
            ALUSrcA    = 1'b1;
            ALUop      = 2'b10;
            next_state = R_WB;
         end
         R_WB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            next_state = FETCH;
            retire     = 1'b1;
         end
         BEQ: begin
            ALUSrcA     = 1'b1;
            ALUop       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            next_state  = FETCH;
            retire      = 1'b1;
         end
         JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            next_state = FETCH;
            retire     = 1'b1;
         end
`ifdef CTRL_EXT_EN
         ADDI_EXE: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            next_state = ADDI_WB;
         end
         ADDI_WB: begin
            RegWrite   = 1'b1;
            next_state = FETCH;
            retire     = 1'b1;
         end
         BNE: begin
            ALUSrcA     = 1'b1;
            ALUop       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            BranchNE    = 1'b1;
            next_state  = FETCH;
            retire      = 1'b1;
         end
`endif
         ERR: err = 1'b1;
         default: next_state = ERR;
      endcase
   end

endmodule
